// File: rtl/axil_reg_master_rd_pkg.sv
// Shared AXI-Lite response codes and the read-initiator state encoding.
package axil_reg_master_rd_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_AR         = 3'd1,
    ST_R          = 3'd2,
    ST_RSP        = 3'd3,
    ST_AR_ABANDON = 3'd4,
    ST_DRAIN      = 3'd5
  } state_t;

endpackage

// File: rtl/axil_reg_master_rd.sv
// AXI-Lite single-beat read initiator with a per-command timeout guard.
// A timed-out read is still completed on the bus (AR held, R beat drained) before the next command.
module axil_reg_master_rd
  import axil_reg_master_rd_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter int          TIMEOUT    = 16,
  parameter logic [2:0]  ARPROT     = 3'b000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  localparam int            TW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  state_t                  state_reg, state_next;
  logic [TW-1:0]           timer_reg, timer_next;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic [1:0]              resp_reg;
  logic                    timeout_reg;
  logic                    rsp_valid_reg;

  logic cmd_fire;
  logic rsp_fire;
  logic beat_fire;
  logic waiting;
  logic handshake;
  logic tmo_fire;

  always_comb begin
    cmd_fire   = (state_reg == ST_IDLE) && cmd_valid;
    rsp_fire   = rsp_valid_reg && rsp_ready;
    beat_fire  = (state_reg == ST_R) && m_axil_rvalid;
    waiting    = (state_reg == ST_AR) || (state_reg == ST_R);
    handshake  = (state_reg == ST_AR) ? m_axil_arready : m_axil_rvalid;
    // A handshake landing in the timer==0 cycle beats the timeout.
    tmo_fire   = (TIMEOUT != 0) && waiting && (timer_reg == '0) && !handshake;

    state_next = state_reg;
    timer_next = timer_reg;
    if (waiting && (timer_reg != '0)) begin
      timer_next = timer_reg - TW'(1);
    end

    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_next = ST_AR;
          timer_next = TIMER_LOAD;
        end
      end
      ST_AR: begin
        if (m_axil_arready)      state_next = ST_R;
        else if (tmo_fire)       state_next = ST_AR_ABANDON;
      end
      ST_R: begin
        if (m_axil_rvalid)       state_next = ST_RSP;
        else if (tmo_fire)       state_next = ST_DRAIN;
      end
      ST_RSP: begin
        if (rsp_ready)           state_next = ST_IDLE;
      end
      ST_AR_ABANDON: begin
        if (m_axil_arready)      state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Beat gone but timeout response still pending: park in RSP until it is taken.
        if (m_axil_rvalid) begin
          state_next = (rsp_valid_reg && !rsp_ready) ? ST_RSP : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      timer_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      if (beat_fire) begin
        rsp_valid_reg <= 1'b1;
        timeout_reg   <= 1'b0;
      end else if (tmo_fire) begin
        rsp_valid_reg <= 1'b1;
        timeout_reg   <= 1'b1;
      end else if (rsp_fire) begin
        rsp_valid_reg <= 1'b0;
      end
    end
  end

  // Address and response payload need no reset; they are only observed alongside a valid.
  always_ff @(posedge clk) begin
    if (cmd_fire) begin
      addr_reg <= cmd_addr;
    end
    if (beat_fire) begin
      data_reg <= m_axil_rdata;
      resp_reg <= m_axil_rresp;
    end else if (tmo_fire) begin
      data_reg <= '0;
      resp_reg <= RESP_SLVERR;
    end
  end

  assign cmd_ready      = (state_reg == ST_IDLE);
  assign m_axil_arvalid = (state_reg == ST_AR) || (state_reg == ST_AR_ABANDON);
  assign m_axil_rready  = (state_reg == ST_R)  || (state_reg == ST_DRAIN);
  assign m_axil_araddr  = addr_reg;
  assign m_axil_arprot  = ARPROT;
  assign rsp_valid      = rsp_valid_reg;
  assign rsp_timeout    = timeout_reg;
  assign rsp_data       = data_reg;
  assign rsp_resp       = resp_reg;

endmodule

// File: tb/tb_axil_reg_master_rd.sv
// Bench for axil_reg_master_rd: two instances (TIMEOUT 16 and 4) share stimulus; a cycle-arithmetic
// model of the read rules predicts every output of the selected instance, cycle by cycle.
module tb_axil_reg_master_rd;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic [31:0] cmd_addr  = '0;
  logic        cmd_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic        arready   = 1'b0;
  logic [31:0] rdata     = '0;
  logic [1:0]  rresp     = '0;
  logic        rvalid    = 1'b0;

  logic        cmd_ready_w   [2];
  logic [31:0] rsp_data_w    [2];
  logic [1:0]  rsp_resp_w    [2];
  logic        rsp_timeout_w [2];
  logic        rsp_valid_w   [2];
  logic [31:0] araddr_w      [2];
  logic [2:0]  arprot_w      [2];
  logic        arvalid_w     [2];
  logic        rready_w      [2];

  int sel       = 0;
  int n_asserts = 0;
  int n_fail    = 0;
  int n_txn     = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      axil_reg_master_rd #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .TIMEOUT((gi == 0) ? 16 : 4),
        .ARPROT(3'b000)
      ) u_dut (
        .clk(clk),
        .rst(rst),
        .cmd_addr(cmd_addr),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready_w[gi]),
        .rsp_data(rsp_data_w[gi]),
        .rsp_resp(rsp_resp_w[gi]),
        .rsp_timeout(rsp_timeout_w[gi]),
        .rsp_valid(rsp_valid_w[gi]),
        .rsp_ready(rsp_ready),
        .m_axil_araddr(araddr_w[gi]),
        .m_axil_arprot(arprot_w[gi]),
        .m_axil_arvalid(arvalid_w[gi]),
        .m_axil_arready(arready),
        .m_axil_rdata(rdata),
        .m_axil_rresp(rresp),
        .m_axil_rvalid(rvalid),
        .m_axil_rready(rready_w[gi])
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_arvalid"},   32'(arvalid_w[sel]),     32'd0);
    chk({tag, "_rready"},    32'(rready_w[sel]),      32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid_w[sel]),   32'd0);
    chk({tag, "_timeout"},   32'(rsp_timeout_w[sel]), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready_w[sel]),   32'd1);
  endtask

  task automatic reset_dut();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    arready   = 1'b0;
    rvalid    = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    chk("arprot", 32'(arprot_w[sel]), 32'd0);
    rst = 1'b0;
  endtask

  // Called at a negedge with the DUT idle. Cycle 0 is the accept cycle; the slave raises arready
  // in cycle 1+ar_dly, rvalid rd cycles after the AR handshake, and rsp_ready after rr cycles.
  task automatic run_txn(input logic [31:0] addr, input int ar_dly, input int r_dly,
                         input logic [31:0] data, input logic [1:0] resp, input int rr_dly);
    int  tmo, c_ar, c_r, f, lim, t_rsp, c_hs, c_idle;
    bit  to;
    tmo  = (sel == 0) ? 16 : 4;
    c_ar = 1 + ar_dly;
    c_r  = c_ar + 1 + r_dly;
    to   = 1'b0;
    f    = 0;
    // Timeout: first cycle >= tmo spent waiting on a handshake that does not happen that cycle.
    if (tmo != 0) begin
      lim = (tmo > c_ar + 1) ? tmo : c_ar + 1;
      if (c_ar > tmo) begin
        to = 1'b1;
        f  = tmo;
      end else if (c_r > lim) begin
        to = 1'b1;
        f  = lim;
      end
    end
    t_rsp  = to ? f + 1 : c_r + 1;
    c_hs   = t_rsp + rr_dly;
    c_idle = (to && (c_r > c_hs)) ? c_r + 1 : c_hs + 1;

    chk("accept_cmd_ready", 32'(cmd_ready_w[sel]), 32'd1);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    for (int c = 1; c <= c_idle; c++) begin
      @(negedge clk);
      chk("arvalid",   32'(arvalid_w[sel]),   32'(c <= c_ar));
      if (c <= c_ar) chk("araddr", araddr_w[sel], addr);
      chk("rready",    32'(rready_w[sel]),    32'((c > c_ar) && (c <= c_r)));
      chk("cmd_ready", 32'(cmd_ready_w[sel]), 32'(c == c_idle));
      chk("rsp_valid", 32'(rsp_valid_w[sel]), 32'((c >= t_rsp) && (c <= c_hs)));
      if ((c >= t_rsp) && (c <= c_hs)) begin
        chk("rsp_data",    rsp_data_w[sel],           to ? 32'd0 : data);
        chk("rsp_resp",    32'(rsp_resp_w[sel]),      to ? 32'd2 : 32'(resp));
        chk("rsp_timeout", 32'(rsp_timeout_w[sel]),   32'(to));
      end
      // Offer stray commands while busy; any early accept shows up as a wrong arvalid.
      cmd_valid = (c < c_idle) ? 1'($urandom) : 1'b0;
      cmd_addr  = $urandom;
      arready   = (c == c_ar);
      rvalid    = (c == c_r);
      rdata     = (c == c_r) ? data : $urandom;
      rresp     = (c == c_r) ? resp : 2'($urandom);
      rsp_ready = (c == c_hs);
    end
    n_txn++;
    $display("txn %0d tmo=%0d addr=%h ar_dly=%0d r_dly=%0d rr_dly=%0d data=%h resp=%0d timeout=%0d",
             n_txn, tmo, addr, ar_dly, r_dly, rr_dly, data, resp, to);
  endtask

  initial begin
    // Default instance (TIMEOUT 16)
    sel = 0;
    @(negedge clk);
    reset_dut();
    run_txn(32'h0000_0010, 0, 0, 32'hDEAD_BEEF, 2'b00, 0);
    run_txn(32'h0000_0044, 5, 3, 32'h1234_5678, 2'b00, 4);
    run_txn(32'h0000_0048, 1, 0, 32'hCAFE_F00D, 2'b11, 1);
    run_txn(32'h0000_004C, 0, 2, 32'h0BAD_CAFE, 2'b01, 0);

    // Reset while in R
    reset_dut();
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_0080;
    @(negedge clk);
    cmd_valid = 1'b0;
    arready   = 1'b1;
    @(negedge clk);
    arready   = 1'b0;
    chk("pre_rst_r_rready", 32'(rready_w[sel]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("rst_in_r");
    rst = 1'b0;

    // Reset while in RSP
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_0084;
    @(negedge clk);
    cmd_valid = 1'b0;
    arready   = 1'b1;
    @(negedge clk);
    arready   = 1'b0;
    rvalid    = 1'b1;
    rdata     = 32'h5555_AAAA;
    rresp     = 2'b11;
    @(negedge clk);
    rvalid    = 1'b0;
    chk("pre_rst_rsp_valid", 32'(rsp_valid_w[sel]), 32'd1);
    chk("pre_rst_rsp_resp",  32'(rsp_resp_w[sel]),  32'd3);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("rst_in_rsp");
    rst = 1'b0;
    run_txn(32'h0000_0088, 0, 0, 32'h7777_0001, 2'b11, 0);

    // TIMEOUT 4 instance: R timeout + drain, exact-boundary beat, AR abandon
    sel = 1;
    reset_dut();
    run_txn(32'h0000_0020, 0, 6, 32'hAAAA_0001, 2'b00, 0);
    run_txn(32'h0000_0024, 0, 0, 32'hBBBB_0002, 2'b00, 0);
    run_txn(32'h0000_0028, 0, 2, 32'hCCCC_0003, 2'b00, 0);
    run_txn(32'h0000_002C, 10, 0, 32'hDDDD_0004, 2'b00, 2);
    run_txn(32'h0000_0030, 3, 0, 32'hEEEE_0005, 2'b10, 0);
    run_txn(32'h0000_0034, 3, 1, 32'hFFFF_0006, 2'b00, 12);

    // Randomized traffic on both instances
    for (int d = 0; d < 2; d++) begin
      sel = (d == 0) ? 1 : 0;
      reset_dut();
      for (int k = 0; k < 25; k++) begin
        run_txn($urandom, $urandom_range(0, 10), $urandom_range(0, 8), $urandom,
                2'($urandom), $urandom_range(0, 3));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
